// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding Wishbone classic initiator driven by a valid/ready command stream
module wb_cmd_master #(
  parameter int C_TIMEOUT = 255,
  parameter int C_AW      = 32,
  parameter int C_DW      = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [C_AW-1:0]   cmd_adr_i,
  input  logic [C_DW-1:0]   cmd_dat_i,
  input  logic [C_DW/8-1:0] cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [C_DW-1:0]   rsp_dat_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [C_DW/8-1:0] wb_sel_o,
  output logic [C_AW-1:0]   wb_adr_o,
  output logic [C_DW-1:0]   wb_dat_o,
  input  logic [C_DW-1:0]   wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic        w_to;
  logic        w_done;
  assign w_to   = (C_TIMEOUT != 0) && (r_cnt == 16'(C_TIMEOUT - 1));
  assign w_done = wb_err_i || wb_ack_i || w_to;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      cmd_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      rsp_dat_o     <= '0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_sel_o      <= '0;
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (cmd_valid_i) begin
          wb_cyc_o    <= 1'b1;
          wb_stb_o    <= 1'b1;
          wb_we_o     <= cmd_we_i;
          wb_adr_o    <= cmd_adr_i;
          wb_dat_o    <= cmd_dat_i;
          wb_sel_o    <= cmd_sel_i;
          r_cnt       <= '0;
          cmd_ready_o <= 1'b0;
          r_state     <= S_BUS;
        end
        S_BUS: if (w_done) begin
          // err outranks ack, ack outranks a timeout landing on the same edge
          wb_cyc_o      <= 1'b0;
          wb_stb_o      <= 1'b0;
          rsp_valid_o   <= 1'b1;
          rsp_err_o     <= wb_err_i || !wb_ack_i;
          rsp_timeout_o <= !wb_err_i && !wb_ack_i;
          rsp_dat_o     <= (!wb_err_i && wb_ack_i && !wb_we_o) ? wb_dat_i : '0;
          r_state       <= S_RESP;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
        S_RESP: if (rsp_ready_i) begin
          rsp_valid_o   <= 1'b0;
          rsp_err_o     <= 1'b0;
          rsp_timeout_o <= 1'b0;
          cmd_ready_o   <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed checks of wb_cmd_master (C_TIMEOUT=8 main instance, C_TIMEOUT=0 side instance)
module tb_wb_cmd_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0, wb_dat_i = '0;
  logic [3:0]  cmd_sel = '0;
  logic        ack = 1'b0, err = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_to, cyc, stb, we;
  logic [31:0] rsp_dat, adr, dat_o;
  logic [3:0]  sel;
  logic        cmd_valid2 = 1'b0, rsp_ready2 = 1'b0, ack2 = 1'b0, err2 = 1'b0;
  logic [31:0] wb_dat_i2 = '0;
  logic        cmd_ready2, rsp_valid2, rsp_err2, rsp_to2, cyc2, stb2, we2;
  logic [31:0] rsp_dat2, adr2, dat_o2;
  logic [3:0]  sel2;
  int n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(.C_TIMEOUT(8), .C_AW(32), .C_DW(32)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .rsp_timeout_o(rsp_to), .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_sel_o(sel),
    .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(ack), .wb_err_i(err));

  wb_cmd_master #(.C_TIMEOUT(0), .C_AW(32), .C_DW(32)) dut2 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2),
    .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_dat_o(rsp_dat2), .rsp_err_o(rsp_err2),
    .rsp_timeout_o(rsp_to2), .wb_cyc_o(cyc2), .wb_stb_o(stb2), .wb_we_o(we2), .wb_sel_o(sel2),
    .wb_adr_o(adr2), .wb_dat_o(dat_o2), .wb_dat_i(wb_dat_i2), .wb_ack_i(ack2), .wb_err_i(err2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int cnt, nb, gap, min_gap, k, nrsp;
    logic pc, acc;
    logic [31:0] adrs [3];
    repeat (3) step();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_cyc_stb_we", {cyc, stb, we}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_to}, 0);
    chk("rst_adr_dat_sel", {adr, sel}, 0);
    chk("rst_dat_o_rsp_dat", {dat_o, rsp_dat}, 0);
    rst_n = 1'b1;
    step();
    // 1: write, acked on the third BUS cycle
    send(1'b1, 32'h0, 32'hEEEEEEEE, 4'hE);
    chk("wr_ready_low", cmd_ready, 0);
    chk("wr_bus", {cyc, stb, we, sel, adr}, {3'b111, 4'hE, 32'h0});
    chk("wr_dat_o", dat_o, 32'hEEEEEEEE);
    cnt = 0;
    while (cyc && cnt < 20) begin
      cnt++;
      ack = (cnt == 3);
      step();
    end
    ack = 1'b0;
    chk("wr_cyc_len", cnt, 3);
    chk("wr_rsp", {rsp_valid, rsp_err, rsp_to, stb}, 4'b1000);
    chk("wr_rsp_dat", rsp_dat, 0);
    release_rsp();
    chk("wr_done", {rsp_valid, cmd_ready}, 2'b01);
    // 2: read, acked in the first BUS cycle, response held while rsp_ready low
    send(1'b0, 32'h4, 32'h0, 4'hF);
    chk("rd_bus", {cyc, stb, we}, 3'b110);
    wb_dat_i = 32'hEEEEEEEE; ack = 1'b1;
    step();
    ack = 1'b0; wb_dat_i = 32'h0;
    chk("rd_rsp", {cyc, rsp_valid, rsp_err, rsp_to}, 4'b0100);
    chk("rd_rsp_dat", rsp_dat, 32'hEEEEEEEE);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rd_hold", {rsp_valid, cmd_ready, cyc, rsp_dat}, {3'b100, 32'hEEEEEEEE});
    end
    release_rsp();
    chk("rd_done", {rsp_valid, cmd_ready}, 2'b01);
    // 3: ack and err together on a read
    send(1'b0, 32'h8, 32'h0, 4'hF);
    wb_dat_i = 32'h12345678; ack = 1'b1; err = 1'b1;
    step();
    ack = 1'b0; err = 1'b0; wb_dat_i = 32'h0;
    chk("err_rsp", {cyc, rsp_valid, rsp_err, rsp_to}, 4'b0110);
    chk("err_rsp_dat", rsp_dat, 0);
    release_rsp();
    // 4: silent slave times out after 8 BUS cycles
    send(1'b0, 32'hC, 32'h0, 4'hF);
    cnt = 0;
    while (cyc && cnt < 40) begin
      cnt++;
      step();
    end
    chk("to_cyc_len", cnt, 8);
    chk("to_rsp", {rsp_valid, rsp_err, rsp_to}, 3'b111);
    chk("to_rsp_dat", rsp_dat, 0);
    release_rsp();
    chk("to_done", {rsp_valid, rsp_err, rsp_to, cmd_ready}, 4'b0001);
    // 4b: timeout disabled keeps the cycle open
    cmd_valid2 = 1'b1;
    step();
    cmd_valid2 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (cyc2 && stb2) cnt++;
      step();
    end
    chk("notimeout_cyc", cnt, 1000);
    chk("notimeout_rsp", {rsp_valid2, cyc2}, 2'b01);
    // 5: asynchronous reset during BUS
    send(1'b1, 32'h20, 32'h55, 4'h1);
    chk("rst_mid_cyc_before", cyc, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_async_drop", {cyc, stb, cmd_ready}, 3'b001);
    step();
    rst_n = 1'b1;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("rst_mid_stray_ack", {cyc, rsp_valid, cmd_ready}, 3'b001);
    // 6: back-to-back writes with valid held and rsp_ready high
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h10; cmd_dat = 32'hA0; cmd_sel = 4'hF;
    rsp_ready = 1'b1;
    nb = 0; gap = 99; min_gap = 99; k = 0; nrsp = 0; pc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      acc = cmd_valid && cmd_ready;
      ack = cyc && stb;
      step();
      if (acc) begin
        k++;
        if (k == 3) cmd_valid = 1'b0;
        cmd_adr = 32'h10 + 32'(4 * k);
        cmd_dat = 32'hA0 + 32'(k);
      end
      if (rsp_valid) nrsp++;
      if (!cyc) gap++;
      else if (!pc) begin
        if (nb < 3) adrs[nb] = adr;
        nb++;
        if (gap < min_gap) min_gap = gap;
        gap = 0;
      end
      pc = cyc;
    end
    ack = 1'b0; rsp_ready = 1'b0;
    chk("b2b_count", nb, 3);
    chk("b2b_rsp_count", nrsp, 3);
    chk("b2b_order", {adrs[0], adrs[1], adrs[2]}, {32'h10, 32'h14, 32'h18});
    chk("b2b_gap_ge2", min_gap >= 2, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("idle_stray_ack", {cyc, rsp_valid, cmd_ready}, 3'b001);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
